// File: rtl/exp2_pp.sv
// Pipelined 2^(e + f/16) from an unsigned Q6.4 log2 value; inverse of the ilog2 unit.
// Latency: 3 cycles from input acceptance to output presentation, 1 result per cycle sustained.
// Backpressure: stalls collapse bubbles; in_ready is combinational from out_ready when full.
module exp2_pp #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_log2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_v,
  output logic        out_sat
);

  // The stage structure below is hard-wired to three registers.
  if (LATENCY != 3) begin : g_latency_check
    $error("exp2_pp only supports LATENCY = 3");
  end

  logic        v1, v2, v3;
  logic        ld1, ld2, ld3;
  logic [5:0]  e1, e2;
  logic [3:0]  f1;
  logic        sat1, sat2, sat3;
  logic [15:0] m1, m2;
  logic [31:0] d3, res;
  logic [5:0]  shl, shr;

  // Each stage loads when empty or when its downstream stage is moving.
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  assign out_valid = v3;
  assign out_v     = d3;
  assign out_sat   = sat3;

  // Mantissa table: round(2^(f/16) * 32768), a Q1.15 value in [1.0, 2.0).
  always_comb begin
    m1 = 16'd32768;
    case (f1)
      4'd0:  m1 = 16'd32768;
      4'd1:  m1 = 16'd34219;
      4'd2:  m1 = 16'd35734;
      4'd3:  m1 = 16'd37316;
      4'd4:  m1 = 16'd38968;
      4'd5:  m1 = 16'd40693;
      4'd6:  m1 = 16'd42495;
      4'd7:  m1 = 16'd44376;
      4'd8:  m1 = 16'd46341;
      4'd9:  m1 = 16'd48393;
      4'd10: m1 = 16'd50535;
      4'd11: m1 = 16'd52773;
      4'd12: m1 = 16'd55109;
      4'd13: m1 = 16'd57549;
      4'd14: m1 = 16'd60097;
      4'd15: m1 = 16'd62757;
      default: m1 = 16'd32768;
    endcase
  end

  // Scale the Q1.15 mantissa by 2^e; unsaturated e is at most 31, so the left shift fits.
  always_comb begin
    res = '0;
    shl = e2 - 6'd15;
    shr = 6'd15 - e2;
    if (sat2) begin
      res = 32'hFFFF_FFFF;
    end else if (e2 >= 6'd15) begin
      res = {16'h0000, m2} << shl;
    end else begin
      res = {16'h0000, m2} >> shr;
    end
  end

  // S1: split the input and flag saturation (e >= 32 is exactly bit 5 of e).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      e1   <= '0;
      f1   <= '0;
      sat1 <= 1'b0;
    end else if (ld1) begin
      v1   <= in_valid;
      e1   <= in_log2[9:4];
      f1   <= in_log2[3:0];
      sat1 <= in_log2[9];
    end
  end

  // S2: register the looked-up mantissa alongside the exponent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2   <= 1'b0;
      e2   <= '0;
      m2   <= '0;
      sat2 <= 1'b0;
    end else if (ld2) begin
      v2   <= v1;
      e2   <= e1;
      m2   <= m1;
      sat2 <= sat1;
    end
  end

  // S3: register the shifted result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3   <= 1'b0;
      d3   <= '0;
      sat3 <= 1'b0;
    end else if (ld3) begin
      v3   <= v2;
      d3   <= res;
      sat3 <= sat2;
    end
  end

endmodule
